mux_n_sequencial: RTL and testbench
===================================

# mux_n_sequencial

Parametrised, registered N-channel multiplexer for the 8-bit datapath, the successor of the fixed 3-input 8-bit combinational mux. Operates in a manual mode (channel chosen by `Controle`, registered) or an automatic scan mode (channels sampled round-robin). It provides a per-sample valid strobe, an out-of-range select flag and an end-of-scan pulse. It sits between register-file/ALU sources and consumers that need a stable, clocked selected operand.

## Interface
- `LARGURA`, 8, data width per channel (≥1)
- `CANAIS`, 3, number of input channels (2..2^`SEL_W`)
- `SEL_W`, 2, select width; must satisfy 2^`SEL_W` ≥ `CANAIS`

Ports:
- `clock`  in  1  single clock; all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `Entradas`  in  `CANAIS`*`LARGURA`  packed inputs; channel k = bits [k*`LARGURA` +: `LARGURA`]
- `Controle`  in  `SEL_W`  channel select, used in manual mode only
- `Modo`  in  1  0 = manual, 1 = scan
- `Habilita`  in  1  capture enable; 0 freezes all state
- `Resultado`  out  `LARGURA`  registered selected data
- `Canal_atual`  out  `SEL_W`  channel index that `Resultado` was taken from
- `Valido`  out  1  one-cycle pulse: `Resultado` updated at this edge
- `Erro`  out  1  registered: last manual capture attempt had `Controle` ≥ `CANAIS`
- `Fim_varredura`  out  1  one-cycle pulse: scan captured channel `CANAIS`-1

## Operation
- Two-state FSM: MANUAL, VARREDURA. Next state = `Modo` at each edge, regardless of `Habilita`.
- Internal pointer `ponteiro` [`SEL_W`] is used in scan mode only.
- Manual, `Habilita`=1, `Controle` < `CANAIS`:
  - `Resultado` ← channel[`Controle`], `Canal_atual` ← `Controle`.
  - `Valido` ← 1, `Erro` ← 0.
- Manual, `Habilita`=1, `Controle` ≥ `CANAIS`:
  - `Resultado` and `Canal_atual` hold.
  - `Valido` ← 0, `Erro` ← 1.
- Scan, `Habilita`=1:
  - Captured channel = 0 if the FSM was in MANUAL (mode entry), else `ponteiro`.
  - `Resultado` ← channel[captured], `Canal_atual` ← captured, `Valido` ← 1, `Erro` ← 0.
  - `ponteiro` ← captured+1, wrapping to 0 after `CANAIS`-1.
  - `Fim_varredura` ← 1 iff captured = `CANAIS`-1.
- Scan, `Habilita`=0:
  - Pointer, `Resultado`, `Canal_atual` and `Erro` hold; `Valido` and `Fim_varredura` ← 0.
  - Scan entry with `Habilita`=0 still resets `ponteiro` to 0.
- Manual, `Habilita`=0: all registers hold except `Valido` and `Fim_varredura` ← 0.
- Scan → manual: `ponteiro` retained but unused; the next scan entry restarts at 0.
- `Controle` is ignored in scan mode; `Erro` is never set in scan mode.
- Width rules:
  - Pointer compare is against `CANAIS`-1, never by `SEL_W` overflow.
  - Non-power-of-2 `CANAIS` must wrap correctly (3 → 0,1,2,0).

## Timing
- Reset (`reset_n`=0, asynchronous, immediate): `Resultado`=0, `Canal_atual`=0, `Valido`=0, `Erro`=0, `Fim_varredura`=0, FSM=MANUAL, `ponteiro`=0.
- Deassertion is sampled at the next rising edge. The first capture may occur at the first edge with `reset_n`=1.
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Input changes between edges have no output effect (no combinational path from input to output).
- Scan throughput: one channel per enabled cycle; a full sweep takes `CANAIS` enabled cycles.
- Reset mid-scan: outputs clear at once; after release the FSM is MANUAL, so `Modo`=1 restarts the scan at channel 0.
- `Modo` and `Habilita` changing in the same cycle: both are sampled at the same edge, and the rules above apply to the new values.

## Test plan
- Reset, then manual mode: `Entradas`={00,55,FF} (ch2,ch1,ch0), `Controle` 0,1,2 over 3 cycles with `Habilita`=1 → `Resultado` FF, 55, 00 one cycle after each select; `Valido`=1 each cycle; `Canal_atual` 0,1,2.
- Manual, `Controle`=3 with `CANAIS`=3 → `Erro`=1, `Valido`=0, `Resultado` holds its previous value; then `Controle`=1 → `Erro`=0, `Resultado`=55.
- Scan, `Habilita`=1 for 7 cycles → `Canal_atual` 0,1,2,0,1,2,0; `Resultado` FF,55,00 repeating; `Fim_varredura` high exactly on the cycles reporting channel 2.
- Scan with `Habilita` dropped for 2 cycles after channel 1 → outputs hold, `Valido`=0; on re-enable, channel 2 is captured next.
- Switch scan→manual→scan mid-sweep → the new sweep restarts at channel 0. Assert `reset_n`=0 between edges mid-scan → all outputs are 0 immediately.
- Parameter sweep `LARGURA`=16, `CANAIS`=4, `SEL_W`=2 → wrap 3→0 correct, no `Erro` in manual mode for select 3.

Source files
------------

// File: rtl/mux_n_sequencial.sv
// Registered N-channel mux: manual select via Controle, or round-robin scan.
// Latency 1 cycle, no backpressure; Habilita=0 freezes state and drops the strobes.
module mux_n_sequencial #(
    parameter int LARGURA = 8,
    parameter int CANAIS  = 3,
    parameter int SEL_W   = 2
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [CANAIS*LARGURA-1:0]   Entradas,
    input  logic [SEL_W-1:0]            Controle,
    input  logic                        Modo,
    input  logic                        Habilita,
    output logic [LARGURA-1:0]          Resultado,
    output logic [SEL_W-1:0]            Canal_atual,
    output logic                        Valido,
    output logic                        Erro,
    output logic                        Fim_varredura
);

    localparam int               NSEL     = 2 ** SEL_W;
    localparam logic [SEL_W:0]   CANAIS_W = (SEL_W + 1)'(CANAIS);
    localparam logic [SEL_W-1:0] ULTIMO   = SEL_W'(CANAIS - 1);

    typedef enum logic {MANUAL = 1'b0, VARREDURA = 1'b1} estado_t;

    estado_t            estado;
    estado_t            proximo;
    logic [SEL_W-1:0]   ponteiro;
    logic [LARGURA-1:0] canais [NSEL];

    logic               captura;
    logic [SEL_W-1:0]   canal_cap;
    logic [SEL_W-1:0]   ponteiro_prox;
    logic               carrega_ponteiro;
    logic               carrega_erro;
    logic               erro_prox;
    logic               fim_prox;
    logic               sel_valido;
    logic [SEL_W-1:0]   canal_scan;

    // Unused select codes read as zero so the mux index never leaves the bus.
    for (genvar k = 0; k < NSEL; k++) begin : g_canais
        if (k < CANAIS) begin : g_ativo
            assign canais[k] = Entradas[k*LARGURA +: LARGURA];
        end else begin : g_vazio
            assign canais[k] = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado <= MANUAL;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = Modo ? VARREDURA : MANUAL;
    end

    always_comb begin
        sel_valido       = ({1'b0, Controle} < CANAIS_W);
        canal_scan       = (estado == MANUAL) ? '0 : ponteiro;
        captura          = 1'b0;
        canal_cap        = Controle;
        ponteiro_prox    = ponteiro;
        carrega_ponteiro = 1'b0;
        carrega_erro     = 1'b0;
        erro_prox        = 1'b0;
        fim_prox         = 1'b0;
        if (Modo) begin
            canal_cap = canal_scan;
            if (Habilita) begin
                captura          = 1'b1;
                carrega_erro     = 1'b1;
                carrega_ponteiro = 1'b1;
                ponteiro_prox    = (canal_scan == ULTIMO) ? '0 : canal_scan + 1'b1;
                fim_prox         = (canal_scan == ULTIMO);
            end else if (estado == MANUAL) begin
                // Entering scan while disabled still restarts the sweep.
                carrega_ponteiro = 1'b1;
                ponteiro_prox    = '0;
            end
        end else if (Habilita) begin
            captura      = sel_valido;
            carrega_erro = 1'b1;
            erro_prox    = !sel_valido;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            Resultado     <= '0;
            Canal_atual   <= '0;
            Valido        <= 1'b0;
            Erro          <= 1'b0;
            Fim_varredura <= 1'b0;
            ponteiro      <= '0;
        end else begin
            Valido        <= captura;
            Fim_varredura <= fim_prox;
            if (captura) begin
                Resultado   <= canais[canal_cap];
                Canal_atual <= canal_cap;
            end
            if (carrega_erro) begin
                Erro <= erro_prox;
            end
            if (carrega_ponteiro) begin
                ponteiro <= ponteiro_prox;
            end
        end
    end

endmodule

// File: tb/tb_mux_n_sequencial.sv
// Bench for mux_n_sequencial: vector table, hand sequences, random run vs reference model.
module tb_mux_n_sequencial;

    localparam int N = 3;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] Entradas = '0;
    logic [1:0]  Controle = '0;
    logic        Modo = 1'b0;
    logic        Habilita = 1'b0;
    logic [7:0]  Resultado;
    logic [1:0]  Canal_atual;
    logic        Valido, Erro, Fim_varredura;

    logic [63:0] e2 = '0;
    logic [1:0]  c2 = '0;
    logic        m2 = 1'b0;
    logic        h2 = 1'b0;
    logic [15:0] r2;
    logic [1:0]  ca2;
    logic        v2, er2, f2;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    mux_n_sequencial #(.LARGURA(8), .CANAIS(3), .SEL_W(2)) dut (
        .clock(clock), .reset_n(reset_n), .Entradas(Entradas), .Controle(Controle),
        .Modo(Modo), .Habilita(Habilita), .Resultado(Resultado), .Canal_atual(Canal_atual),
        .Valido(Valido), .Erro(Erro), .Fim_varredura(Fim_varredura)
    );

    mux_n_sequencial #(.LARGURA(16), .CANAIS(4), .SEL_W(2)) dut4 (
        .clock(clock), .reset_n(reset_n), .Entradas(e2), .Controle(c2),
        .Modo(m2), .Habilita(h2), .Resultado(r2), .Canal_atual(ca2),
        .Valido(v2), .Erro(er2), .Fim_varredura(f2)
    );

    // Reference model: state kept as plain integers, stepped once per rising edge.
    int       m_ptr;
    bit       m_was_scan;
    int       m_res;
    int       m_ch;
    bit       m_val, m_err, m_fim;

    function automatic void model_reset();
        m_ptr = 0; m_was_scan = 0; m_res = 0; m_ch = 0;
        m_val = 0; m_err = 0; m_fim = 0;
    endfunction

    function automatic int chan(input logic [23:0] ent, input int k);
        return int'((ent >> (8 * k)) & 24'hFF);
    endfunction

    function automatic void model_step(input bit modo, input bit hab, input int ctrl,
                                       input logic [23:0] ent);
        int cap;
        m_val = 0;
        m_fim = 0;
        if (!modo) begin
            if (hab) begin
                if (ctrl < N) begin
                    m_res = chan(ent, ctrl); m_ch = ctrl; m_val = 1; m_err = 0;
                end else begin
                    m_err = 1;
                end
            end
        end else begin
            cap = m_was_scan ? m_ptr : 0;
            if (hab) begin
                m_res = chan(ent, cap); m_ch = cap; m_val = 1; m_err = 0;
                m_ptr = (cap + 1) % N;
                m_fim = (cap == N - 1);
            end else if (!m_was_scan) begin
                m_ptr = 0;
            end
        end
        m_was_scan = modo;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_step(Modo, Habilita, int'(Controle), Entradas);
        #1;
    endtask

    typedef struct {
        logic       modo;
        logic       hab;
        logic [1:0] ctrl;
        logic [7:0] res;
        logic [1:0] ch;
        logic       val;
        logic       err;
        logic       fim;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic mo, input logic ha, input logic [1:0] ct,
                                input logic [7:0] re, input logic [1:0] ch,
                                input logic va, input logic er, input logic fi);
        vec_t v;
        v.modo = mo; v.hab = ha; v.ctrl = ct; v.res = re; v.ch = ch;
        v.val = va; v.err = er; v.fim = fi;
        tbl.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        model_reset();

        add(0,1,0, 8'hFF,0,1,0,0);
        add(0,1,1, 8'h55,1,1,0,0);
        add(0,1,2, 8'h00,2,1,0,0);
        add(0,1,3, 8'h00,2,0,1,0);
        add(0,1,1, 8'h55,1,1,0,0);
        add(1,1,0, 8'hFF,0,1,0,0);
        add(1,1,3, 8'h55,1,1,0,0);
        add(1,1,0, 8'h00,2,1,0,1);
        add(1,1,0, 8'hFF,0,1,0,0);
        add(1,1,0, 8'h55,1,1,0,0);
        add(1,1,0, 8'h00,2,1,0,1);
        add(1,1,0, 8'hFF,0,1,0,0);
        add(1,1,0, 8'h55,1,1,0,0);
        add(1,0,0, 8'h55,1,0,0,0);
        add(1,0,0, 8'h55,1,0,0,0);
        add(1,1,0, 8'h00,2,1,0,1);
        add(1,1,0, 8'hFF,0,1,0,0);
        add(1,1,0, 8'h55,1,1,0,0);
        add(0,0,0, 8'h55,1,0,0,0);
        add(1,1,0, 8'hFF,0,1,0,0);
        add(0,1,3, 8'hFF,0,0,1,0);
        add(1,0,0, 8'hFF,0,0,1,0);
        add(1,1,0, 8'hFF,0,1,0,0);
        add(0,1,1, 8'h55,1,1,0,0);
        add(1,0,0, 8'h55,1,0,0,0);
        add(1,1,0, 8'hFF,0,1,0,0);

        Entradas = {8'h00, 8'h55, 8'hFF};
        #2;
        check("reset Resultado", 32'(Resultado), 0);
        check("reset Canal_atual", 32'(Canal_atual), 0);
        check("reset Valido", 32'(Valido), 0);
        check("reset Erro", 32'(Erro), 0);
        check("reset Fim_varredura", 32'(Fim_varredura), 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            Modo = tbl[i].modo; Habilita = tbl[i].hab; Controle = tbl[i].ctrl;
            step();
            check($sformatf("vec%0d Resultado", i), 32'(Resultado), 32'(tbl[i].res));
            check($sformatf("vec%0d Canal_atual", i), 32'(Canal_atual), 32'(tbl[i].ch));
            check($sformatf("vec%0d Valido", i), 32'(Valido), 32'(tbl[i].val));
            check($sformatf("vec%0d Erro", i), 32'(Erro), 32'(tbl[i].err));
            check($sformatf("vec%0d Fim_varredura", i), 32'(Fim_varredura), 32'(tbl[i].fim));
        end

        // Inputs moving between edges must not reach the outputs.
        Entradas = 24'h123456; Controle = 2'd2;
        #2;
        check("no comb path Resultado", 32'(Resultado), 32'hFF);
        Entradas = {8'h00, 8'h55, 8'hFF};

        // Asynchronous reset in the middle of a sweep.
        Modo = 1; Habilita = 1;
        step();
        check("pre-reset Canal_atual", 32'(Canal_atual), 1);
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        check("async reset Resultado", 32'(Resultado), 0);
        check("async reset Canal_atual", 32'(Canal_atual), 0);
        check("async reset Valido", 32'(Valido), 0);
        #2 reset_n = 1'b1;
        step();
        check("post-reset Resultado", 32'(Resultado), 32'hFF);
        check("post-reset Canal_atual", 32'(Canal_atual), 0);
        check("post-reset Valido", 32'(Valido), 1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) Modo = ~Modo;
            Habilita = ($urandom_range(0, 3) != 0);
            Controle = 2'($urandom_range(0, 3));
            Entradas = 24'($urandom);
            step();
            check("rnd Resultado", 32'(Resultado), 32'(m_res));
            check("rnd Canal_atual", 32'(Canal_atual), 32'(m_ch));
            check("rnd Valido", 32'(Valido), 32'(m_val));
            check("rnd Erro", 32'(Erro), 32'(m_err));
            check("rnd Fim_varredura", 32'(Fim_varredura), 32'(m_fim));
        end

        // Four-channel, 16-bit instance: select 3 is legal and the sweep wraps 3 -> 0.
        e2 = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
        m2 = 0; h2 = 1; c2 = 2'd3;
        step();
        check("w16 manual sel3 Resultado", 32'(r2), 32'hDDDD);
        check("w16 manual sel3 Erro", 32'(er2), 0);
        check("w16 manual sel3 Valido", 32'(v2), 1);
        m2 = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            w = e2[(i % 4) * 16 +: 16];
            check($sformatf("w16 scan%0d Canal_atual", i), 32'(ca2), 32'(i % 4));
            check($sformatf("w16 scan%0d Resultado", i), 32'(r2), 32'(w));
            check($sformatf("w16 scan%0d Fim_varredura", i), 32'(f2), 32'((i % 4) == 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
